// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: NOP/zero constants, hold levels, buffer entry layout.
package ifu_pkg;

    localparam int INST_DATA_WIDTH = 32;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int HOLD_BUS_WIDTH  = 3;

    // addi x0, x0, 0 -- what decode sees whenever nothing valid is presented
    localparam logic [INST_DATA_WIDTH-1:0] INST_NOP  = 32'h0000_0013;
    localparam logic [INST_ADDR_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic [HOLD_BUS_WIDTH-1:0] {
        Hold_None = 3'd0,
        Hold_Pc   = 3'd1,
        Hold_If   = 3'd2,
        Hold_Id   = 3'd3
    } hold_lvl_e;

    typedef struct packed {
        logic [INST_DATA_WIDTH-1:0] inst;
        logic [INST_ADDR_WIDTH-1:0] addr;
    } ibuf_entry_t;

    // Queue depth must be a power of two so the pointers wrap for free.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ifu_ibuf_ctrl.sv
// Queue bookkeeping for the instruction buffer: pointers, occupancy, handshake decode.
module ifu_ibuf_ctrl
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             hold,
    input  logic             flush,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             in_ready,
    output logic             out_valid
);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pop;

    // Ready depends only on stored occupancy, so a pop cannot open a slot in the same cycle.
    assign in_ready  = (count_reg != CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0) & ~hold;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_ptr = wr_ptr_reg;
    assign rd_ptr = rd_ptr_reg;
    assign count  = count_reg;

    // Next-state arithmetic; a flush overrides any push or pop seen this cycle.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_reg == CNT_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (count_reg == '0)));

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("ifu_ibuf_ctrl: DEPTH must be a power of two and at least 2");
    end

endmodule

// File: rtl/ifu_ibuf.sv
// Instruction buffer between fetch and decode: FIFO storage plus hold-squashed output mux.
module ifu_ibuf
    import ifu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                INST_W   = INST_DATA_WIDTH,
    parameter int                ADDR_W   = INST_ADDR_WIDTH,
    parameter int                HOLD_W   = HOLD_BUS_WIDTH,
    parameter logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(Hold_If)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inst_valid_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic [ADDR_W-1:0]          inst_addr_i,
    output logic                       inst_ready_o,
    input  logic                       flush_i,
    input  logic [HOLD_W-1:0]          hold_flag_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int E_W   = INST_W + ADDR_W;

    logic             hold;
    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [E_W-1:0]   mem [DEPTH];
    logic [E_W-1:0]   head;

    assign hold = (hold_flag_i >= HOLD_LVL);

    ifu_ibuf_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inst_valid_i),
        .out_ready (inst_ready_i),
        .hold      (hold),
        .flush     (flush_i),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count_o),
        .in_ready  (inst_ready_o),
        .out_valid (inst_valid_o)
    );

    // Capture accepted responses; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {inst_i, inst_addr_i};
        end
    end

    // Head is read straight from storage; anything not presented as valid becomes a NOP bubble.
    assign head        = mem[rd_ptr];
    assign inst_o      = inst_valid_o ? head[E_W-1:ADDR_W] : INST_W'(INST_NOP);
    assign inst_addr_o = inst_valid_o ? head[ADDR_W-1:0]   : ADDR_W'(ZERO_WORD);

endmodule

// File: tb/tb_ifu_ibuf.sv
// Self-checking bench for ifu_ibuf: vector table plus hand sequences, all checked by a queue scoreboard.
module tb_ifu_ibuf;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [2:0]  H_NONE = 3'd0;
    localparam logic [2:0]  H_PC   = 3'd1;
    localparam logic [2:0]  H_IF   = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_ready_o;
    logic        flush_i = 1'b0;
    logic [2:0]  hold_flag_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    ifu_ibuf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_ready_o (inst_ready_o),
        .flush_i      (flush_i),
        .hold_flag_i  (hold_flag_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .count_o      (count_o)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb[$];      // expected {inst, addr} in arrival order
    int          m_count = 0;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        rdy;
        logic [2:0]  hold;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[12];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance the model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                        input logic rdy, input logic [2:0] hold, input logic flush);
        logic        exp_ready;
        logic        exp_valid;
        logic        do_push;
        logic        do_pop;
        logic [63:0] head;
        inst_valid_i = v;
        inst_i       = inst;
        inst_addr_i  = addr;
        inst_ready_i = rdy;
        hold_flag_i  = hold;
        flush_i      = flush;
        #4;
        exp_ready = (m_count != DEPTH);
        exp_valid = (m_count != 0) && (hold < H_IF);
        head      = exp_valid ? sb[0] : {NOP, 32'h0};
        chk("ready", 32'(inst_ready_o), 32'(exp_ready));
        chk("valid", 32'(inst_valid_o), 32'(exp_valid));
        chk("count", 32'(count_o), 32'(m_count));
        chk("inst",  inst_o, head[63:32]);
        chk("addr",  inst_addr_o, head[31:0]);
        do_push = v && exp_ready && !flush;
        do_pop  = exp_valid && rdy && !flush;
        if (flush) begin
            sb.delete();
            $display("[TB] flush");
        end else begin
            if (do_pop) begin
                $display("[TB] pop  inst=%h addr=%h", head[63:32], head[31:0]);
                void'(sb.pop_front());
            end
            if (do_push) begin
                sb.push_back({inst, addr});
                $display("[TB] push inst=%h addr=%h", inst, addr);
            end
        end
        m_count = sb.size();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, H_NONE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0013, 32'h8000_0000, 1'b1, H_NONE, 3'd1};
        vecs[1]  = '{1'b1, 32'h0010_0093, 32'h8000_0004, 1'b1, H_NONE, 3'd1};
        vecs[2]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_NONE, 3'd0};
        vecs[3]  = '{1'b1, 32'hAAAA_0001, 32'h8000_0100, 1'b0, H_NONE, 3'd1};
        vecs[4]  = '{1'b1, 32'hAAAA_0002, 32'h8000_0104, 1'b0, H_NONE, 3'd2};
        vecs[5]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_IF,   3'd2};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_IF,   3'd2};
        vecs[7]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_IF,   3'd2};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_NONE, 3'd1};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         1'b1, H_NONE, 3'd0};
        vecs[10] = '{1'b1, 32'hBBBB_0001, 32'h8000_0200, 1'b0, H_PC,   3'd1};
        vecs[11] = '{1'b0, 32'h0,         32'h0,         1'b1, H_PC,   3'd0};

        // Reset state
        #1;
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_ready", 32'(inst_ready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_inst",  inst_o, NOP);
        chk("rst_addr",  inst_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: in-order delivery, hold squash and resume, sub-level hold ignored
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].v, vecs[i].inst, vecs[i].addr, vecs[i].rdy, vecs[i].hold, 1'b0);
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
        end

        // Full: fifth response is held upstream until the first pop has happened
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'hC0DE_0000 + k, 32'h8000_0000 + 4 * k, 1'b0, H_NONE, 1'b0);
        chk("full_ready", 32'(inst_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        repeat (2) step(1'b1, 32'hC0DE_0004, 32'h8000_0010, 1'b0, H_NONE, 1'b0);
        chk("full_hold_count", 32'(count_o), 32'd4);
        step(1'b1, 32'hC0DE_0004, 32'h8000_0010, 1'b1, H_NONE, 1'b0);
        chk("full_pop_count", 32'(count_o), 32'd3);
        step(1'b1, 32'hC0DE_0004, 32'h8000_0010, 1'b1, H_NONE, 1'b0);
        chk("full_refill_count", 32'(count_o), 32'd3);
        repeat (3) idle(1'b1);
        chk("full_drain_count", 32'(count_o), 32'd0);

        // Simultaneous push and pop at count 2 across pointer wrap
        for (int n = 0; n < 2; n++)
            step(1'b1, 32'hD000_0000 + n, 32'h8000_0000 + 4 * n, 1'b0, H_NONE, 1'b0);
        for (int n = 2; n < 12; n++) begin
            step(1'b1, 32'hD000_0000 + n, 32'h8000_0000 + 4 * n, 1'b1, H_NONE, 1'b0);
            chk($sformatf("wrap%0d_count", n), 32'(count_o), 32'd2);
        end
        repeat (2) idle(1'b1);

        // Flush with count 3 and a same-cycle push, under hold
        for (int n = 0; n < 3; n++)
            step(1'b1, 32'hE000_0000 + n, 32'h8000_0300 + 4 * n, 1'b0, H_NONE, 1'b0);
        step(1'b1, 32'hE000_0003, 32'h8000_030C, 1'b1, H_IF, 1'b1);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(inst_valid_o), 32'd0);
        step(1'b1, 32'hE000_0004, 32'h8000_0310, 1'b0, H_NONE, 1'b0);
        chk("post_flush_count", 32'(count_o), 32'd1);
        idle(1'b1);

        // Asynchronous reset mid-stream
        for (int n = 0; n < 2; n++)
            step(1'b1, 32'hF000_0000 + n, 32'h8000_0400 + 4 * n, 1'b0, H_NONE, 1'b0);
        inst_valid_i = 1'b0;
        inst_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid_o), 32'd0);
        chk("arst_ready", 32'(inst_ready_o), 32'd1);
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_inst",  inst_o, NOP);
        chk("arst_addr",  inst_addr_o, 32'h0);
        sb.delete();
        m_count = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'hF000_0010, 32'h8000_0000, 1'b1, H_NONE, 1'b0);
        idle(1'b1);
        chk("arst_end_count", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
